// File: rtl/backprop_layer_scheduler_pkg.sv
// Shared definitions for the backprop layer scheduler: state encoding and
// the default watchdog limit.
package backprop_layer_scheduler_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DELTA = 2'd1,
    ST_WAIT_WC    = 2'd2,
    ST_FINISH     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/backprop_layer_scheduler_watchdog.sv
// Watchdog for the weight-controller wait: counts enabled cycles from a clear
// and flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
module sched_watchdog #(
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/backprop_layer_scheduler.sv
// Walks one weight-update sweep from the last layer down to layer 0:
// delta request, weight-controller start pulse, wait for valid under a watchdog.
module backprop_layer_scheduler
  import backprop_layer_scheduler_pkg::*;
#(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int TIMEOUT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LAYER_ADDR_WIDTH:0]   layer_count,
  input  logic                        abort,
  output logic                        delta_req,
  input  logic                        delta_valid,
  output logic                        wc_start,
  output logic [LAYER_ADDR_WIDTH-1:0] wc_layer,
  input  logic                        wc_valid,
  input  logic                        wc_error,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic                        timeout,
  output logic                        error,
  output logic [LAYER_ADDR_WIDTH-1:0] err_layer,
  output logic [1:0]                  state_dbg
);

  // Handshakes: delta_req holds high until delta_valid is sampled in WAIT_DELTA;
  // wc_start is a single-cycle pulse and the wait ends on the first sampled
  // wc_valid in WAIT_WC. Responses outside their wait state are ignored.

  sched_state_t state_q, state_d;

  logic                        delta_req_d, wc_start_d, busy_d, done_d;
  logic                        aborted_d, timeout_d, error_d;
  logic [LAYER_ADDR_WIDTH-1:0] wc_layer_d, err_layer_d;
  logic                        wd_clear, wd_enable, wd_expired;

  sched_watchdog #(
    .COUNT_WIDTH   (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  assign wd_enable = (state_q == ST_WAIT_WC);
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    delta_req_d = delta_req;
    wc_start_d  = 1'b0;
    wc_layer_d  = wc_layer;
    busy_d      = busy;
    done_d      = 1'b0;
    aborted_d   = aborted;
    timeout_d   = timeout;
    error_d     = error;
    err_layer_d = err_layer;
    wd_clear    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          aborted_d   = 1'b0;
          timeout_d   = 1'b0;
          error_d     = 1'b0;
          err_layer_d = '0;
          if (layer_count == '0) begin
            state_d = ST_FINISH;
          end else begin
            // Counts at or above 1<<LAYER_ADDR_WIDTH start from the top layer.
            if (layer_count[LAYER_ADDR_WIDTH]) wc_layer_d = '1;
            else wc_layer_d = layer_count[LAYER_ADDR_WIDTH-1:0] - 1'b1;
            delta_req_d = 1'b1;
            state_d     = ST_WAIT_DELTA;
          end
        end
      end

      ST_WAIT_DELTA: begin
        if (abort) begin
          delta_req_d = 1'b0;
          aborted_d   = 1'b1;
          state_d     = ST_FINISH;
        end else if (delta_valid) begin
          delta_req_d = 1'b0;
          wc_start_d  = 1'b1;
          wd_clear    = 1'b1;
          state_d     = ST_WAIT_WC;
        end
      end

      ST_WAIT_WC: begin
        if (wc_error && !error) begin
          error_d     = 1'b1;
          err_layer_d = wc_layer;
        end
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FINISH;
        end else if (wc_valid) begin
          if (wc_layer == '0) begin
            state_d = ST_FINISH;
          end else begin
            wc_layer_d  = wc_layer - 1'b1;
            delta_req_d = 1'b1;
            state_d     = ST_WAIT_DELTA;
          end
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          aborted_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      delta_req <= 1'b0;
      wc_start  <= 1'b0;
      wc_layer  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      timeout   <= 1'b0;
      error     <= 1'b0;
      err_layer <= '0;
    end else begin
      state_q   <= state_d;
      delta_req <= delta_req_d;
      wc_start  <= wc_start_d;
      wc_layer  <= wc_layer_d;
      busy      <= busy_d;
      done      <= done_d;
      aborted   <= aborted_d;
      timeout   <= timeout_d;
      error     <= error_d;
      err_layer <= err_layer_d;
    end
  end

endmodule
